// File: rtl/grid_cursor_if.sv
`default_nettype none
// ============================================================================
//  Module   : grid_cursor_if
//  Purpose  : Key-stream, load and cursor-status bundle for grid_cursor.
//             The master drives keys/load and observes the cursor; the slave
//             is the cursor controller itself.
//  Revision : 1.0  initial release
// ============================================================================
interface grid_cursor_if #(
    parameter int XW = 4,
    parameter int YW = 4
) ();

    logic          key_valid;
    logic [7:0]    key_code;
    logic          load;
    logic [XW-1:0] load_x;
    logic [YW-1:0] load_y;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          select;
    logic          moved;
    logic          edge_hit;

    modport master (
        output key_valid, key_code, load, load_x, load_y,
        input  cur_x, cur_y, select, moved, edge_hit
    );

    modport slave (
        input  key_valid, key_code, load, load_x, load_y,
        output cur_x, cur_y, select, moved, edge_hit
    );

endinterface : grid_cursor_if
`default_nettype wire

// File: rtl/grid_cursor.sv
`default_nettype none
// ============================================================================
//  Module   : grid_cursor
//  Purpose  : (x, y) cursor on a COLS x ROWS board driven by decoded PS/2
//             scan codes. Understands the E0 (extended) and F0 (break)
//             prefixes so WASD and the arrow keys both move the cursor;
//             Enter pulses select, Esc returns home. Edges saturate
//             (WRAP=0) or wrap (WRAP=1). An external load overrides keys.
//  Option   : GRID_CURSOR_TYPEMATIC_FILTER_EN - when defined, repeated makes
//             of the currently held key are ignored until its break arrives.
//  Revision : 1.0  initial release
// ============================================================================
module grid_cursor #(
    parameter int COLS   = 9,
    parameter int ROWS   = 10,
    parameter int XW     = 4,
    parameter int YW     = 4,
    parameter int WRAP   = 0,
    parameter int HOME_X = 0,
    parameter int HOME_Y = 0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    grid_cursor_if.slave   bus_io
);

    // ------------------------------------------------------------------------
    // Constants at the working widths of the two axes
    // ------------------------------------------------------------------------
    localparam logic [XW-1:0] c_x_max    = XW'(COLS - 1);
    localparam logic [YW-1:0] c_y_max    = YW'(ROWS - 1);
    localparam logic [XW:0]   c_cols_ext = (XW+1)'(COLS);
    localparam logic [YW:0]   c_rows_ext = (YW+1)'(ROWS);
    localparam logic [XW-1:0] c_home_x   = XW'(HOME_X);
    localparam logic [YW-1:0] c_home_y   = YW'(HOME_Y);

    localparam logic [7:0] c_pfx_ext = 8'hE0;
    localparam logic [7:0] c_pfx_brk = 8'hF0;

    // ------------------------------------------------------------------------
    // Prefix state machine
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } pfx_state_t;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_LEFT  = 3'd1,
        CMD_RIGHT = 3'd2,
        CMD_UP    = 3'd3,
        CMD_DOWN  = 3'd4,
        CMD_SEL   = 3'd5,
        CMD_HOME  = 3'd6
    } cmd_t;

    pfx_state_t state_q, state_d;

    logic       w_make;     // a complete make code is present this cycle
    logic       w_brk;      // a complete break code is present this cycle
    logic       w_ext;      // the completed code carried the E0 prefix
    logic [8:0] w_key9;     // {ext, code} identity of the completed key
    logic       w_accept;   // make survives the typematic filter
    cmd_t       w_cmd;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          sel_q, sel_d;
    logic          mov_q, mov_d;
    logic          edge_q, edge_d;

    logic [XW-1:0] w_load_x;
    logic [YW-1:0] w_load_y;

    // Prefix state register; reset abandons any half-received sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Prefix next-state and classification of the byte that completes a code
    always_comb begin
        state_d = state_q;
        w_make  = 1'b0;
        w_brk   = 1'b0;
        w_ext   = 1'b0;
        if (bus_io.key_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus_io.key_code == c_pfx_ext) begin
                        state_d = ST_EXT;
                    end else if (bus_io.key_code == c_pfx_brk) begin
                        state_d = ST_BRK;
                    end else begin
                        w_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (bus_io.key_code == c_pfx_brk) begin
                        state_d = ST_EXT_BRK;
                    end else if (bus_io.key_code == c_pfx_ext) begin
                        state_d = ST_EXT;
                    end else begin
                        w_make  = 1'b1;
                        w_ext   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_brk   = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_brk   = 1'b1;
                    w_ext   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign w_key9 = {w_ext, bus_io.key_code};

`ifdef GRID_CURSOR_TYPEMATIC_FILTER_EN
    // ------------------------------------------------------------------------
    // Typematic filter: remembers the last accepted make until its break
    // ------------------------------------------------------------------------
    logic [8:0] held_q, held_d;
    logic       held_vld_q, held_vld_d;

    // Held-key register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q     <= 9'd0;
            held_vld_q <= 1'b0;
        end else begin
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
        end
    end

    // Drop repeats of the held key; a new make replaces it, its break frees it
    always_comb begin
        held_d     = held_q;
        held_vld_d = held_vld_q;
        w_accept   = w_make;
        if (w_make) begin
            if (held_vld_q && (held_q == w_key9)) begin
                w_accept = 1'b0;
            end else begin
                held_d     = w_key9;
                held_vld_d = 1'b1;
            end
        end else if (w_brk && held_vld_q && (held_q == w_key9)) begin
            held_vld_d = 1'b0;
        end
    end
`else
    // Every make is acted on, so typematic repeats keep moving the cursor
    assign w_accept = w_make;
`endif

    // Map an accepted make to a cursor command; breaks never reach here
    always_comb begin
        w_cmd = CMD_NONE;
        if (w_accept) begin
            case (w_key9)
                9'h01C, 9'h16B: w_cmd = CMD_LEFT;
                9'h023, 9'h174: w_cmd = CMD_RIGHT;
                9'h01D, 9'h175: w_cmd = CMD_UP;
                9'h01B, 9'h172: w_cmd = CMD_DOWN;
                9'h05A, 9'h15A: w_cmd = CMD_SEL;
                9'h076:         w_cmd = CMD_HOME;
                default:        w_cmd = CMD_NONE;
            endcase
        end
    end

    // Out-of-range load coordinates are pinned to the last column/row
    assign w_load_x = ({1'b0, bus_io.load_x} >= c_cols_ext) ? c_x_max : bus_io.load_x;
    assign w_load_y = ({1'b0, bus_io.load_y} >= c_rows_ext) ? c_y_max : bus_io.load_y;

    // Next position and event pulses; load wins over any key this cycle
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        sel_d  = 1'b0;
        mov_d  = 1'b0;
        edge_d = 1'b0;
        if (bus_io.load) begin
            x_d = w_load_x;
            y_d = w_load_y;
        end else begin
            case (w_cmd)
                CMD_LEFT: begin
                    if (x_q == '0) begin
                        if (WRAP != 0) begin
                            x_d   = c_x_max;
                            mov_d = 1'b1;
                        end else begin
                            edge_d = 1'b1;
                        end
                    end else begin
                        x_d   = x_q - 1'b1;
                        mov_d = 1'b1;
                    end
                end
                CMD_RIGHT: begin
                    if (x_q >= c_x_max) begin
                        if (WRAP != 0) begin
                            x_d   = '0;
                            mov_d = 1'b1;
                        end else begin
                            edge_d = 1'b1;
                        end
                    end else begin
                        x_d   = x_q + 1'b1;
                        mov_d = 1'b1;
                    end
                end
                CMD_UP: begin
                    if (y_q == '0) begin
                        if (WRAP != 0) begin
                            y_d   = c_y_max;
                            mov_d = 1'b1;
                        end else begin
                            edge_d = 1'b1;
                        end
                    end else begin
                        y_d   = y_q - 1'b1;
                        mov_d = 1'b1;
                    end
                end
                CMD_DOWN: begin
                    if (y_q >= c_y_max) begin
                        if (WRAP != 0) begin
                            y_d   = '0;
                            mov_d = 1'b1;
                        end else begin
                            edge_d = 1'b1;
                        end
                    end else begin
                        y_d   = y_q + 1'b1;
                        mov_d = 1'b1;
                    end
                end
                CMD_SEL: begin
                    sel_d = 1'b1;
                end
                CMD_HOME: begin
                    // Only report movement when home is actually somewhere else
                    if ((x_q != c_home_x) || (y_q != c_home_y)) begin
                        x_d   = c_home_x;
                        y_d   = c_home_y;
                        mov_d = 1'b1;
                    end
                end
                default: begin
                    x_d = x_q;
                end
            endcase
        end
    end

    // Cursor position and one-cycle event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= c_home_x;
            y_q    <= c_home_y;
            sel_q  <= 1'b0;
            mov_q  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            sel_q  <= sel_d;
            mov_q  <= mov_d;
            edge_q <= edge_d;
        end
    end

    assign bus_io.cur_x    = x_q;
    assign bus_io.cur_y    = y_q;
    assign bus_io.select   = sel_q;
    assign bus_io.moved    = mov_q;
    assign bus_io.edge_hit = edge_q;

endmodule : grid_cursor
`default_nettype wire

// File: tb/tb_grid_cursor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grid_cursor
//  Purpose  : Self-checking bench for grid_cursor. One instance saturates at
//             the edges, a second wraps. Vectors carry the inputs for one
//             cycle and the outputs expected one clock later.
//  Revision : 1.0  initial release
// ============================================================================
module tb_grid_cursor;

`ifdef GRID_CURSOR_TYPEMATIC_FILTER_EN
    localparam bit c_filt = 1'b1;
`else
    localparam bit c_filt = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    grid_cursor_if #(.XW(4), .YW(4)) b0 ();
    grid_cursor_if #(.XW(4), .YW(4)) b1 ();

    grid_cursor #(
        .COLS(9), .ROWS(10), .XW(4), .YW(4), .WRAP(0), .HOME_X(0), .HOME_Y(0)
    ) u_dut_sat (
        .clk    (clk),
        .rst    (rst),
        .bus_io (b0)
    );

    grid_cursor #(
        .COLS(9), .ROWS(10), .XW(4), .YW(4), .WRAP(1), .HOME_X(0), .HOME_Y(0)
    ) u_dut_wrap (
        .clk    (clk),
        .rst    (rst),
        .bus_io (b1)
    );

    typedef struct {
        bit         dut;    // 0 = saturating instance, 1 = wrapping instance
        bit         ld;
        logic [3:0] lx;
        logic [3:0] ly;
        bit         kv;
        logic [7:0] code;
        logic [3:0] ex;
        logic [3:0] ey;
        bit         es;
        bit         em;
        bit         ee;
    } vec_t;

    vec_t vt[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(bit dut, bit ld, int lx, int ly, bit kv, int code,
                                int ex, int ey, bit es, bit em, bit ee);
        vec_t v;
        v.dut  = dut;
        v.ld   = ld;
        v.lx   = 4'(lx);
        v.ly   = 4'(ly);
        v.kv   = kv;
        v.code = 8'(code);
        v.ex   = 4'(ex);
        v.ey   = 4'(ey);
        v.es   = es;
        v.em   = em;
        v.ee   = ee;
        return v;
    endfunction

    function automatic vec_t key(bit dut, int code, int ex, int ey, bit es, bit em, bit ee);
        return mk(dut, 1'b0, 0, 0, 1'b1, code, ex, ey, es, em, ee);
    endfunction

    function automatic vec_t ldv(bit dut, int lx, int ly, bit kv, int code, int ex, int ey);
        return mk(dut, 1'b1, lx, ly, kv, code, ex, ey, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t idle(bit dut, int ex, int ey);
        return mk(dut, 1'b0, 0, 0, 1'b0, 0, ex, ey, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic drive_idle();
        b0.key_valid = 1'b0; b0.key_code = 8'h00; b0.load = 1'b0; b0.load_x = '0; b0.load_y = '0;
        b1.key_valid = 1'b0; b1.key_code = 8'h00; b1.load = 1'b0; b1.load_x = '0; b1.load_y = '0;
    endtask

    task automatic drive(vec_t v);
        drive_idle();
        if (v.dut == 1'b0) begin
            b0.key_valid = v.kv; b0.key_code = v.code; b0.load = v.ld; b0.load_x = v.lx; b0.load_y = v.ly;
        end else begin
            b1.key_valid = v.kv; b1.key_code = v.code; b1.load = v.ld; b1.load_x = v.lx; b1.load_y = v.ly;
        end
    endtask

    task automatic check(string tag);
        vec_t        e;
        logic [10:0] act;
        logic [10:0] req;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, no expected value available", tag);
            return;
        end
        e   = exp_q.pop_front();
        act = e.dut ? {b1.cur_x, b1.cur_y, b1.select, b1.moved, b1.edge_hit}
                    : {b0.cur_x, b0.cur_y, b0.select, b0.moved, b0.edge_hit};
        req = {e.ex, e.ey, e.es, e.em, e.ee};
        if (act !== req) begin
            n_err++;
            $display("FAIL %s (dut%0d): got x=%0d y=%0d sel=%b mov=%b edge=%b, expected x=%0d y=%0d sel=%b mov=%b edge=%b",
                     tag, e.dut, act[10:7], act[6:3], act[2], act[1], act[0],
                     req[10:7], req[6:3], req[2], req[1], req[0]);
        end
    endtask

    task automatic apply(vec_t v, string tag);
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check(tag);
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();

        // ---------------- saturating instance ----------------
        vt.push_back(idle(0, 0, 0));
        vt.push_back(idle(1, 0, 0));
        vt.push_back(key(0, 'h23, 1, 0, 0, 1, 0));
        vt.push_back(key(0, 'hF0, 1, 0, 0, 0, 0));
        vt.push_back(key(0, 'h23, 1, 0, 0, 0, 0));
        vt.push_back(key(0, 'h1B, 1, 1, 0, 1, 0));
        vt.push_back(idle(0, 1, 1));
        vt.push_back(key(0, 'hE0, 1, 1, 0, 0, 0));
        vt.push_back(key(0, 'h6B, 0, 1, 0, 1, 0));
        vt.push_back(key(0, 'h1C, 0, 1, 0, 0, 1));
        vt.push_back(key(0, 'h1D, 0, 0, 0, 1, 0));
        vt.push_back(key(0, 'hE0, 0, 0, 0, 0, 0));
        vt.push_back(key(0, 'h75, 0, 0, 0, 0, 1));
        vt.push_back(ldv(0, 12, 3, 1'b1, 'h23, 8, 3));
        vt.push_back(key(0, 'hE0, 8, 3, 0, 0, 0));
        vt.push_back(key(0, 'h74, 8, 3, 0, 0, 1));
        vt.push_back(key(0, 'h23, 8, 3, 0, 0, 1));
        vt.push_back(ldv(0, 5, 15, 1'b0, 0, 5, 9));
        vt.push_back(key(0, 'h1B, 5, 9, 0, 0, 1));
        vt.push_back(key(0, 'hE0, 5, 9, 0, 0, 0));
        vt.push_back(key(0, 'h72, 5, 9, 0, 0, 1));
        vt.push_back(key(0, 'hE0, 5, 9, 0, 0, 0));
        vt.push_back(key(0, 'hF0, 5, 9, 0, 0, 0));
        vt.push_back(key(0, 'h5A, 5, 9, 0, 0, 0));
        vt.push_back(key(0, 'h5A, 5, 9, 1, 0, 0));
        vt.push_back(idle(0, 5, 9));
        vt.push_back(key(0, 'hE0, 5, 9, 0, 0, 0));
        vt.push_back(key(0, 'h5A, 5, 9, 1, 0, 0));
        vt.push_back(key(0, 'h76, 0, 0, 0, 1, 0));
        vt.push_back(key(0, 'h76, 0, 0, 0, 0, 0));
        vt.push_back(key(0, 'hE0, 0, 0, 0, 0, 0));
        vt.push_back(key(0, 'hE0, 0, 0, 0, 0, 0));
        vt.push_back(key(0, 'h1C, 0, 0, 0, 0, 0));
        vt.push_back(ldv(0, 3, 3, 1'b0, 0, 3, 3));
        vt.push_back(key(0, 'hE0, 3, 3, 0, 0, 0));
        vt.push_back(key(0, 'h76, 3, 3, 0, 0, 0));
        vt.push_back(key(0, 'h76, 0, 0, 0, 1, 0));
        vt.push_back(ldv(0, 2, 2, 1'b1, 'hE0, 2, 2));
        vt.push_back(key(0, 'h6B, 1, 2, 0, 1, 0));
        // held-key repeats: filter gives two increments, no filter four
        vt.push_back(ldv(0, 0, 5, 1'b0, 0, 0, 5));
        vt.push_back(key(0, 'h23, 1, 5, 0, 1, 0));
        vt.push_back(key(0, 'h23, c_filt ? 1 : 2, 5, 0, !c_filt, 0));
        vt.push_back(key(0, 'h23, c_filt ? 1 : 3, 5, 0, !c_filt, 0));
        vt.push_back(key(0, 'hF0, c_filt ? 1 : 3, 5, 0, 0, 0));
        vt.push_back(key(0, 'h23, c_filt ? 1 : 3, 5, 0, 0, 0));
        vt.push_back(key(0, 'h23, c_filt ? 2 : 4, 5, 0, 1, 0));
        // ---------------- wrapping instance ----------------
        vt.push_back(key(1, 'hE0, 0, 0, 0, 0, 0));
        vt.push_back(key(1, 'h6B, 8, 0, 0, 1, 0));
        vt.push_back(key(1, 'h23, 0, 0, 0, 1, 0));
        vt.push_back(key(1, 'h1D, 0, 9, 0, 1, 0));
        vt.push_back(key(1, 'h1B, 0, 0, 0, 1, 0));
        vt.push_back(ldv(1, 12, 3, 1'b1, 'h23, 8, 3));
        vt.push_back(key(1, 'h23, 0, 3, 0, 1, 0));
        vt.push_back(idle(1, 0, 3));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of an E0 prefix: next byte is decoded from IDLE
        apply(ldv(0, 3, 4, 1'b0, 0, 3, 4), "rst_pre_load");
        apply(key(0, 'hE0, 3, 4, 0, 0, 0), "rst_pre_e0");
        @(negedge clk);
        rst = 1'b1;
        #2;
        exp_q.push_back(idle(0, 0, 0));
        check("rst_async");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply(key(0, 'h72, 0, 0, 0, 0, 0), "rst_post_72");
        apply(idle(0, 0, 0), "rst_post_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_grid_cursor
`default_nettype wire
